// File: rtl/ro_odometer_pkg.sv
// ro_odometer_pkg: shared state encoding, frequency width and delta saturation value
package ro_odometer_pkg;
  localparam int FREQ_W = 32;
  localparam logic [FREQ_W-1:0] DELTA_SAT = '1;
  typedef enum logic [2:0] {IDLE, GO, STRESS, MEAS, WAIT, EVAL, NEXT, DONE} state_e;
endpackage

// File: rtl/cdir_delta_cmp.sv
// cdir_delta_cmp: non-wrapping reference-minus-stressed delta and strict threshold compare
module cdir_delta_cmp
  import ro_odometer_pkg::*;
(
  input  logic [FREQ_W-1:0] r_freq,
  input  logic [FREQ_W-1:0] s_freq,
  input  logic [FREQ_W-1:0] thr,
  input  logic              sat,
  output logic [FREQ_W-1:0] delta,
  output logic              over
);
  assign delta = sat ? DELTA_SAT : (r_freq >= s_freq ? r_freq - s_freq : '0);
  assign over = delta > thr;
endmodule

// File: rtl/ro_odometer_scan_ctrl.sv
// ro_odometer_scan_ctrl: sequences go/stress/measure over every CDIR sensor pair
// and flags pairs whose frequency delta exceeds the latched threshold.
module ro_odometer_scan_ctrl
  import ro_odometer_pkg::*;
#(
  parameter int NO_CDIR      = 8,
  parameter int MUX_SEL_SIZE = $clog2(NO_CDIR),
  parameter int STRESS_CYC   = 64,
  parameter int TIMEOUT_CYC  = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [31:0]             threshold,
  input  logic                    odo_valid_out,
  input  logic [31:0]             odo_r_freq,
  input  logic [31:0]             odo_s_freq,
  output logic                    odo_go,
  output logic                    odo_en_out,
  output logic [MUX_SEL_SIZE-1:0] odo_r_mux_sel,
  output logic [MUX_SEL_SIZE-1:0] odo_s_mux_sel,
  output logic                    res_valid,
  output logic [MUX_SEL_SIZE-1:0] res_idx,
  output logic [31:0]             res_delta,
  output logic [NO_CDIR-1:0]      flag_vec,
  output logic                    recycled,
  output logic                    timeout_err,
  output logic                    busy,
  output logic                    done
);
  state_e state_q, state_d;
  logic [MUX_SEL_SIZE-1:0] idx_q, idx_d;
  logic [FREQ_W-1:0] thr_q, thr_d, r_q, r_d, s_q, s_d, delta;
  logic [31:0] cnt_q, cnt_d;
  logic sat_q, sat_d, over;
  logic [NO_CDIR-1:0] flag_vec_q, flag_vec_d;
  logic recycled_q, recycled_d, timeout_err_q, timeout_err_d;

  cdir_delta_cmp u_cmp (
    .r_freq(r_q),
    .s_freq(s_q),
    .thr   (thr_q),
    .sat   (sat_q),
    .delta (delta),
    .over  (over)
  );

  // one counter serves both the stress window and the valid_out timeout
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    thr_d = thr_q;
    cnt_d = cnt_q + 32'd1;
    r_d = r_q;
    s_d = s_q;
    sat_d = sat_q;
    flag_vec_d = flag_vec_q;
    timeout_err_d = timeout_err_q;
    case (state_q)
      IDLE: if (start) begin
        thr_d = threshold;
        flag_vec_d = '0;
        timeout_err_d = 1'b0;
        idx_d = '0;
        state_d = GO;
      end
      GO: begin
        cnt_d = '0;
        state_d = STRESS;
      end
      STRESS: if (cnt_q == 32'(STRESS_CYC - 1)) state_d = MEAS;
      MEAS: begin
        cnt_d = '0;
        state_d = WAIT;
      end
      WAIT: if (odo_valid_out) begin
        r_d = odo_r_freq;
        s_d = odo_s_freq;
        sat_d = 1'b0;
        state_d = EVAL;
      end else if (cnt_q == 32'(TIMEOUT_CYC - 1)) begin
        sat_d = 1'b1;
        timeout_err_d = 1'b1;
        state_d = EVAL;
      end
      EVAL: begin
        flag_vec_d[idx_q] = over;
        state_d = NEXT;
      end
      NEXT: if (idx_q == MUX_SEL_SIZE'(NO_CDIR - 1)) state_d = DONE;
      else begin
        idx_d = idx_q + 1'b1;
        state_d = GO;
      end
      default: state_d = IDLE;
    endcase
    recycled_d = |flag_vec_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      idx_q <= '0;
      thr_q <= '0;
      cnt_q <= '0;
      r_q <= '0;
      s_q <= '0;
      sat_q <= 1'b0;
      flag_vec_q <= '0;
      recycled_q <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      thr_q <= thr_d;
      cnt_q <= cnt_d;
      r_q <= r_d;
      s_q <= s_d;
      sat_q <= sat_d;
      flag_vec_q <= flag_vec_d;
      recycled_q <= recycled_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign odo_go = state_q == GO;
  assign odo_en_out = state_q == MEAS;
  assign odo_r_mux_sel = idx_q;
  assign odo_s_mux_sel = idx_q;
  assign res_valid = state_q == EVAL;
  assign res_idx = res_valid ? idx_q : '0;
  assign res_delta = res_valid ? delta : '0;
  assign flag_vec = flag_vec_q;
  assign recycled = recycled_q;
  assign timeout_err = timeout_err_q;
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
endmodule

// File: tb/tb_ro_odometer_scan_ctrl.sv
// tb_ro_odometer_scan_ctrl: directed scans against a behavioural odometer and result model
module tb_ro_odometer_scan_ctrl;
  localparam int N = 8, SC = 64, TO = 1024;
  logic clk = 0, rst = 0, start = 0, odo_valid_out = 0;
  logic [31:0] threshold = 0, odo_r_freq = 0, odo_s_freq = 0;
  logic odo_go, odo_en_out, res_valid, recycled, timeout_err, busy, done;
  logic [2:0] odo_r_mux_sel, odo_s_mux_sel, res_idx;
  logic [31:0] res_delta;
  logic [N-1:0] flag_vec;

  ro_odometer_scan_ctrl #(.NO_CDIR(N), .STRESS_CYC(SC), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .threshold(threshold),
    .odo_valid_out(odo_valid_out), .odo_r_freq(odo_r_freq), .odo_s_freq(odo_s_freq),
    .odo_go(odo_go), .odo_en_out(odo_en_out), .odo_r_mux_sel(odo_r_mux_sel),
    .odo_s_mux_sel(odo_s_mux_sel), .res_valid(res_valid), .res_idx(res_idx),
    .res_delta(res_delta), .flag_vec(flag_vec), .recycled(recycled),
    .timeout_err(timeout_err), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  logic [31:0] r_tab[N], s_tab[N], got_delta[N], thr_m;
  logic [N-1:0] no_resp = '0;
  bit spur = 0;
  int exp_idx = 0, res_cnt = 0, done_cnt = 0, go_cnt = 0;

  function automatic logic [31:0] exp_delta(input int i);
    if (no_resp[i]) return 32'hFFFF_FFFF;
    return r_tab[i] >= s_tab[i] ? r_tab[i] - s_tab[i] : 32'd0;
  endfunction

  function automatic logic [N-1:0] exp_flags();
    logic [N-1:0] f;
    for (int i = 0; i < N; i++) f[i] = exp_delta(i) > thr_m;
    return f;
  endfunction

  task automatic set_tab(input logic [31:0] r, input logic [31:0] s);
    for (int i = 0; i < N; i++) begin
      r_tab[i] = r;
      s_tab[i] = s;
    end
  endtask

  // odometer model: answers each en_out three cycles later, optionally glitches valid during stress
  initial begin
    int lat, spur_lat, sel_l;
    lat = 0;
    spur_lat = 0;
    sel_l = 0;
    forever begin
      @(negedge clk);
      odo_valid_out = 0;
      if (!rst) begin
        lat = 0;
        spur_lat = 0;
      end else begin
        if (lat > 0) begin
          lat--;
          if (lat == 0) begin
            odo_valid_out = 1;
            odo_r_freq = r_tab[sel_l];
            odo_s_freq = s_tab[sel_l];
          end
        end
        if (spur_lat > 0) begin
          spur_lat--;
          if (spur_lat == 0) begin
            odo_valid_out = 1;
            odo_r_freq = 32'h7777_0000;
            odo_s_freq = 0;
          end
        end
        if (odo_en_out && !no_resp[odo_r_mux_sel]) begin
          lat = 3;
          sel_l = int'(odo_r_mux_sel);
        end
        if (spur && odo_go) spur_lat = 5;
      end
    end
  end

  initial begin
    int cyc, go_cyc, en_cyc;
    logic prev_go, prev_en;
    cyc = 0;
    go_cyc = 0;
    en_cyc = 0;
    prev_go = 0;
    prev_en = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        if (res_valid) begin
          if (exp_idx >= N) chk("res_extra", exp_idx, N - 1);
          else begin
            chk("res_idx", res_idx, exp_idx);
            chk("res_delta", res_delta, exp_delta(exp_idx));
            chk("res_mux", {odo_r_mux_sel, odo_s_mux_sel}, {3'(exp_idx), 3'(exp_idx)});
            chk("wait_len", cyc - en_cyc, no_resp[exp_idx] ? TO + 1 : 4);
            got_delta[exp_idx] = res_delta;
            exp_idx++;
            res_cnt++;
          end
        end
        if (odo_go) begin
          chk("go_single", prev_go, 0);
          chk("go_mux", {odo_r_mux_sel, odo_s_mux_sel}, {3'(exp_idx), 3'(exp_idx)});
          go_cyc = cyc;
          go_cnt++;
        end
        if (odo_en_out) begin
          chk("en_single", prev_en, 0);
          chk("stress_gap", cyc - go_cyc - 1, SC);
          chk("en_mux", {odo_r_mux_sel, odo_s_mux_sel}, {3'(exp_idx), 3'(exp_idx)});
          en_cyc = cyc;
        end
        if (done) begin
          done_cnt++;
          chk("done_res_cnt", res_cnt, N);
          chk("done_go_cnt", go_cnt, N);
          chk("done_flags", flag_vec, exp_flags());
          chk("done_recycled", recycled, |exp_flags());
          chk("done_timeout", timeout_err, |no_resp);
          chk("done_busy", busy, 1);
        end
      end
      prev_go = rst && odo_go;
      prev_en = rst && odo_en_out;
    end
  end

  task automatic wait_done(input int d0);
    for (int i = 0; i < 20000 && done_cnt == d0; i++) @(negedge clk);
    chk("scan_done", done_cnt - d0, 1);
  endtask

  task automatic run_scan(input logic [31:0] thr, input bit poke);
    int d0;
    thr_m = thr;
    exp_idx = 0;
    res_cnt = 0;
    go_cnt = 0;
    d0 = done_cnt;
    @(negedge clk);
    start = 1;
    threshold = thr;
    @(negedge clk);
    start = 0;
    chk("busy_after_start", busy, 1);
    if (poke) begin
      repeat (30) @(negedge clk);
      start = 1;
      threshold = 0;
      @(negedge clk);
      start = 0;
    end
    wait_done(d0);
    repeat (3) @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("hold_flags", flag_vec, exp_flags());
    chk("hold_recycled", recycled, |exp_flags());
    chk("hold_timeout", timeout_err, |no_resp);
    chk("one_done", done_cnt - d0, 1);
    chk("res_count", res_cnt, N);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int r0, d0;
    set_tab(1000, 950);
    repeat (3) @(negedge clk);
    chk("reset_outputs", {odo_go, odo_en_out, odo_r_mux_sel, odo_s_mux_sel, res_valid, res_idx,
        res_delta, flag_vec, recycled, timeout_err, busy, done}, 0);
    rst = 1;
    repeat (3) @(negedge clk);
    chk("idle_no_start", busy, 0);

    spur = 1;
    run_scan(100, 1);
    spur = 0;
    chk("normal_delta0", got_delta[0], 50);
    chk("normal_delta7", got_delta[7], 50);
    chk("normal_flags", flag_vec, 8'h00);

    s_tab[5] = 800;
    run_scan(100, 0);
    chk("aging_delta5", got_delta[5], 200);
    chk("aging_flags", flag_vec, 8'h20);
    chk("aging_recycled", recycled, 1);

    set_tab(1000, 950);
    s_tab[0] = 900;
    r_tab[1] = 500;
    s_tab[1] = 700;
    r_tab[2] = 1001;
    s_tab[2] = 900;
    run_scan(100, 0);
    chk("bound_eq_delta", got_delta[0], 100);
    chk("bound_neg_delta", got_delta[1], 0);
    chk("bound_flags", flag_vec, 8'h04);

    set_tab(1000, 950);
    no_resp = 8'h08;
    run_scan(100, 0);
    chk("to_delta3", got_delta[3], 32'hFFFF_FFFF);
    chk("to_delta7", got_delta[7], 50);
    chk("to_flags", flag_vec, 8'h08);
    chk("to_err", timeout_err, 1);
    no_resp = '0;

    s_tab[0] = 0;
    thr_m = 100;
    exp_idx = 0;
    res_cnt = 0;
    go_cnt = 0;
    @(negedge clk);
    start = 1;
    threshold = 100;
    @(negedge clk);
    start = 0;
    for (int i = 0; i < 2000 && go_cnt < 3; i++) @(negedge clk);
    chk("reach_sensor2", go_cnt, 3);
    repeat (10) @(negedge clk);
    chk("pre_reset_flags", flag_vec, 8'h01);
    r0 = res_cnt;
    d0 = done_cnt;
    #2 rst = 0;
    #1;
    chk("async_reset_outputs", {odo_go, odo_en_out, odo_r_mux_sel, odo_s_mux_sel, res_valid, res_idx,
        res_delta, flag_vec, recycled, timeout_err, busy, done}, 0);
    repeat (5) @(negedge clk);
    rst = 1;
    repeat (5) @(negedge clk);
    chk("post_reset_idle", busy, 0);
    chk("post_reset_no_done", done_cnt - d0, 0);
    chk("post_reset_no_res", res_cnt - r0, 0);
    run_scan(100, 0);
    chk("rescan_flags", flag_vec, 8'h01);
    chk("rescan_delta0", got_delta[0], 1000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
